// File: rtl/microwave_timer.sv
// BCD MM:SS cook-time counter paired with the microwave control FSM.
// Optional add-30-seconds key is enabled by defining MICROWAVE_TIMER_ADD30_EN.
module microwave_timer #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned PRESC_W       = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mag_on,
    input  logic        clear,
`ifdef MICROWAVE_TIMER_ADD30_EN
    input  logic        add30,
`endif
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    output logic [15:0] time_bcd,
    output logic        timer_done,
    output logic        sec_tick
);

    localparam logic [PRESC_W-1:0] PrescMax = PRESC_W'(TICKS_PER_SEC - 1);

    logic [15:0]        time_q, time_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               done_q, done_d;
    logic               tick_q, tick_d;
    logic               key_accept;
    logic               run_en;

    // One-second BCD decrement; the all-zero case never reaches here.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else if (st != 4'd0) begin
            st = st - 4'd1;
            so = 4'd9;
        end else begin
            st = 4'd5;
            so = 4'd9;
            if (mo != 4'd0) begin
                mo = mo - 4'd1;
            end else begin
                mo = 4'd9;
                mt = mt - 4'd1;
            end
        end
        return {mt, mo, st, so};
    endfunction

`ifdef MICROWAVE_TIMER_ADD30_EN
    function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
        logic [7:0] tens;
        logic [7:0] ones;
        tens = v / 8'd10;
        ones = v - tens * 8'd10;
        return {tens[3:0], ones[3:0]};
    endfunction

    // Seconds may hold an un-normalised 60..99, so the sum can reach 129.
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [7:0] sec_bin;
        logic [7:0] min_bin;
        sec_bin = {4'd0, t[7:4]} * 8'd10 + {4'd0, t[3:0]} + 8'd30;
        min_bin = {4'd0, t[15:12]} * 8'd10 + {4'd0, t[11:8]};
        if (sec_bin >= 8'd60) begin
            sec_bin = sec_bin - 8'd60;
            min_bin = min_bin + 8'd1;
        end
        if (min_bin > 8'd99) begin
            return 16'h9959;
        end
        return {bin_to_bcd(min_bin), bin_to_bcd(sec_bin)};
    endfunction
`endif

    assign key_accept = key_valid & ~mag_on & (key_digit <= 4'd9);
    assign run_en     = mag_on & (time_q != 16'h0000);

    always_comb begin
        time_d  = time_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (clear) begin
            time_d  = 16'h0000;
            presc_d = '0;
`ifdef MICROWAVE_TIMER_ADD30_EN
        end else if (add30) begin
            time_d  = bcd_add30(time_q);
            presc_d = '0;
`endif
        end else if (key_accept) begin
            time_d  = {time_q[11:0], key_digit};
            presc_d = '0;
        end else if (run_en) begin
            if (presc_q == PrescMax) begin
                presc_d = '0;
                time_d  = bcd_dec(time_q);
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign done_d = (time_d == 16'h0000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_q  <= 16'h0000;
            presc_q <= '0;
            done_q  <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            time_q  <= time_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
        end
    end

    assign time_bcd   = time_q;
    assign timer_done = done_q;
    assign sec_tick   = tick_q;

endmodule

// File: tb/tb_microwave_timer.sv
// Self-checking bench for microwave_timer: directed steps then random traffic,
// checked against a minutes/seconds arithmetic model.
module tb_microwave_timer;

    localparam int unsigned TICKS = 4;
`ifdef MICROWAVE_TIMER_ADD30_EN
    localparam bit A30_EN = 1'b1;
`else
    localparam bit A30_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        mag_on;
    logic        clear;
`ifdef MICROWAVE_TIMER_ADD30_EN
    logic        add30;
`endif
    logic        key_valid;
    logic [3:0]  key_digit;
    logic [15:0] time_bcd;
    logic        timer_done;
    logic        sec_tick;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: remaining time as plain integers plus elapsed sub-second cycles.
    int m_min  = 0;
    int m_sec  = 0;
    int m_frac = 0;
    bit m_tick = 1'b0;

    microwave_timer #(
        .TICKS_PER_SEC(TICKS),
        .PRESC_W      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mag_on    (mag_on),
        .clear     (clear),
`ifdef MICROWAVE_TIMER_ADD30_EN
        .add30     (add30),
`endif
        .key_valid (key_valid),
        .key_digit (key_digit),
        .time_bcd  (time_bcd),
        .timer_done(timer_done),
        .sec_tick  (sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_bcd();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic model_reset();
        m_min  = 0;
        m_sec  = 0;
        m_frac = 0;
        m_tick = 1'b0;
    endtask

    task automatic model_step(input bit mg, input bit clr, input bit kv,
                              input logic [3:0] kd, input bit a30);
        int n;
        m_tick = 1'b0;
        if (clr) begin
            m_min  = 0;
            m_sec  = 0;
            m_frac = 0;
        end else if (a30) begin
            m_sec = m_sec + 30;
            if (m_sec >= 60) begin
                m_sec = m_sec - 60;
                m_min = m_min + 1;
            end
            if (m_min > 99) begin
                m_min = 99;
                m_sec = 59;
            end
            m_frac = 0;
        end else if (kv && !mg) begin
            if (kd <= 4'd9) begin
                n      = ((m_min * 100 + m_sec) * 10 + int'(kd)) % 10000;
                m_min  = n / 100;
                m_sec  = n % 100;
                m_frac = 0;
            end
        end else if (mg && (m_min != 0 || m_sec != 0)) begin
            if (m_frac == int'(TICKS) - 1) begin
                m_frac = 0;
                m_tick = 1'b1;
                if (m_sec > 0) begin
                    m_sec = m_sec - 1;
                end else begin
                    m_min = m_min - 1;
                    m_sec = 59;
                end
            end else begin
                m_frac = m_frac + 1;
            end
        end
    endtask

    task automatic check_model();
        chk16("time_bcd", time_bcd, exp_bcd());
        chk1("timer_done", timer_done, (m_min == 0 && m_sec == 0));
        chk1("sec_tick", sec_tick, m_tick);
    endtask

    // One clock with the given inputs; outputs sampled 1 time unit after the edge.
    task automatic cycle(input bit mg, input bit clr, input bit kv,
                         input logic [3:0] kd, input bit a30);
        mag_on    = mg;
        clear     = clr;
        key_valid = kv;
        key_digit = kd;
`ifdef MICROWAVE_TIMER_ADD30_EN
        add30     = a30;
`endif
        @(posedge clk);
        model_step(mg, clr, kv, kd, A30_EN && a30);
        #1;
        check_model();
    endtask

    task automatic idle(input int n, input bit mg);
        for (int i = 0; i < n; i++) cycle(mg, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic key(input logic [3:0] d);
        cycle(1'b0, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic load(input logic [15:0] v);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        key(v[15:12]);
        key(v[11:8]);
        key(v[7:4]);
        key(v[3:0]);
    endtask

    logic [15:0] load_tab [3] = '{16'h0100, 16'h1000, 16'h0190};
    logic [15:0] res_tab  [3] = '{16'h0059, 16'h0959, 16'h0189};

    initial begin
        bit mg;
        rst       = 1'b1;
        mag_on    = 1'b0;
        clear     = 1'b0;
        key_valid = 1'b0;
        key_digit = 4'd0;
`ifdef MICROWAVE_TIMER_ADD30_EN
        add30     = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk16("rst_time", time_bcd, 16'h0000);
        chk1("rst_done", timer_done, 1'b1);
        chk1("rst_tick", sec_tick, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Zero count with magnetron on must not move
        idle(20, 1'b1);
        chk16("zero_hold", time_bcd, 16'h0000);

        key(4'd1);
        key(4'd3);
        key(4'd0);
        chk16("keys_130", time_bcd, 16'h0130);
        chk1("keys_done", timer_done, 1'b0);
        key(4'hA);
        chk16("key_gt9", time_bcd, 16'h0130);
        cycle(1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
        chk16("key_mag_on", time_bcd, 16'h0130);

        load(16'h0002);
        idle(4, 1'b1);
        chk16("run2_first", time_bcd, 16'h0001);
        chk1("run2_tick", sec_tick, 1'b1);
        idle(4, 1'b1);
        chk16("run2_zero", time_bcd, 16'h0000);
        chk1("run2_done", timer_done, 1'b1);
        idle(10, 1'b1);
        chk16("run2_hold", time_bcd, 16'h0000);

        for (int i = 0; i < 3; i++) begin
            load(load_tab[i]);
            idle(4, 1'b1);
            chk16("borrow", time_bcd, res_tab[i]);
        end

        // Pause keeps the fractional second
        load(16'h0005);
        idle(6, 1'b1);
        idle(10, 1'b0);
        chk16("pause_hold", time_bcd, 16'h0004);
        idle(1, 1'b1);
        chk16("resume_1", time_bcd, 16'h0004);
        idle(1, 1'b1);
        chk16("resume_2", time_bcd, 16'h0003);
        chk1("resume_tick", sec_tick, 1'b1);
        idle(3, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        chk16("clear_on_tick", time_bcd, 16'h0000);
        chk1("clear_no_tick", sec_tick, 1'b0);

        // Asynchronous reset in the middle of a countdown
        load(16'h0030);
        idle(7, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk16("async_rst_time", time_bcd, 16'h0000);
        chk1("async_rst_done", timer_done, 1'b1);
        chk1("async_rst_tick", sec_tick, 1'b0);
        model_reset();
        mag_on = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(2, 1'b0);

`ifdef MICROWAVE_TIMER_ADD30_EN
        load(16'h0045);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk16("add30_0045", time_bcd, 16'h0115);
        load(16'h9945);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        chk16("add30_sat", time_bcd, 16'h9959);
        load(16'h0010);
        idle(3, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        chk16("add30_on_tick", time_bcd, 16'h0040);
        chk1("add30_no_tick", sec_tick, 1'b0);
        idle(1, 1'b0);
`endif

        mg = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) mg = ~mg;
            cycle(mg,
                  $urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)),
                  A30_EN && ($urandom_range(0, 24) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- BCD MM:SS cook-time counter that is the counterpart of the microwave `control` FSM.
- Consumes `mag_on` from `control` and produces the `timer_done` that `control` samples.
- Keypad digits shift in while idle. Count decrements once per second while the magnetron is on.
- `timer_done` is held high whenever the remaining time is zero.

Parameters:
- TICKS_PER_SEC, 50_000_000, clk cycles per one-second decrement (min 2; sim uses 4)
- PRESC_W, 26, prescaler width; must satisfy 2**PRESC_W >= TICKS_PER_SEC

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mag_on  input  1  from control; high = cooking, countdown enabled
- clear  input  1  synchronous active-high clear of remaining time
- key_valid  input  1  one-cycle strobe: key_digit valid
- key_digit  input  4  BCD digit 0..9 from keypad
- time_bcd  output  16  {min_tens, min_ones, sec_tens, sec_ones}, registered
- timer_done  output  1  registered; high iff time_bcd == 16'h0000
- sec_tick  output  1  one-cycle pulse on each applied decrement

Behaviour:
- Reset (async, rst=1) puts the block in this state:
  - time_bcd = 0000, timer_done = 1, sec_tick = 0, prescaler = 0.
- Priority per clk edge, highest first:
  1. clear
  2. add30 (see Optional Feature)
  3. key entry
  4. countdown tick
- Clear: clear=1 makes time_bcd 0000 and prescaler 0 next cycle, regardless of mag_on.
- Key entry is accepted only when key_valid=1, mag_on=0 and key_digit <= 9:
  - shift left one digit: mt<=mo, mo<=st, st<=so, so<=key_digit
  - prescaler <= 0
  - a digit above 9 or a strobe while mag_on=1 is ignored, with no state change
- Entered values are not normalised. Seconds field 00..99 is legal (e.g. 01:90).
- Prescaler:
  - increments only when mag_on=1 and time_bcd != 0
  - on reaching TICKS_PER_SEC-1 it wraps to 0 and generates a tick
  - holds its value while mag_on=0, so pause/resume keeps the fractional second
- Tick decrement, BCD with borrow:
  - so>0: so-1
  - so=0, st>0: st-1, so=9
  - sec=00, min>0: min-1 with BCD borrow (mo 0 -> 9, mt-1), sec = 59
  - sec=00 and min=00 is unreachable (prescaler gated)
- sec_tick is high for exactly the cycle after a tick is applied.
- timer_done:
  - registered compare of the next-state count against zero, so it rises in the same cycle time_bcd becomes 0000
  - latency from final tick to timer_done=1 is 1 clk
  - stays high until a nonzero digit is loaded or added
- Count reaching 0000 while mag_on=1:
  - prescaler freezes at 0
  - no further ticks
  - no underflow or wrap to 99:59
- mag_on falling mid-second: count holds and the prescaler holds.
- rst asserted mid-countdown: immediate return to reset values. No partial tick is emitted.

Optional Feature:
- Macro: MICROWAVE_TIMER_ADD30_EN
- Defined:
  - adds input port `add30` (1 bit, one-cycle strobe), honoured regardless of mag_on
  - seconds field += 30 (BCD); if result >= 60, subtract 60 and increment minutes (BCD)
  - if minutes would exceed 99, count saturates at 99:59
  - prescaler <= 0
  - a coincident tick is discarded: no decrement, no sec_tick
- Undefined: the port is absent and the logic is not synthesised. Behaviour equals the base spec.

Test Plan:
- rst=1 then release -> time_bcd=0000, timer_done=1, sec_tick=0. With mag_on=1 for 20 clks -> no change.
- mag_on=0, keys 1,3,0 -> time_bcd=0130, timer_done=0. Key 0xA -> unchanged. Key 5 with mag_on=1 -> unchanged.
- TICKS_PER_SEC=4, load 0002, mag_on=1:
  - ticks at clk 4 and 8 -> 0001 then 0000
  - timer_done=1 in the same cycle as 0000
  - holds 0000 for 10 further clks
- Load 0100, run 1 s -> 0059. Load 1000, run 1 s -> 0959. Load 0190, run 1 s -> 0189.
- Load 0005, mag_on=1 for 6 clks, mag_on=0 for 10 clks (count 0004 held), mag_on=1 -> next tick after 2 more clks -> 0003. clear=1 coincident with a tick -> 0000, sec_tick=0.
- With MICROWAVE_TIMER_ADD30_EN:
  - 0045 + add30 -> 0115
  - 9945 + add30 -> 9959
  - add30 on the tick cycle -> +30 applied, no decrement, no sec_tick
